// File: rtl/rfq_ctrl.sv
// FIFO controller in front of a 1W/1R register file with registered read data and a
// 2-entry output stage. Define RFQ_CTRL_BYPASS_EN to let pushes skip storage when idle.
module rfq_ctrl #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_vld,
  input  logic [W-1:0]            push_data,
  output logic                    push_rdy,
  output logic                    pop_vld,
  output logic [W-1:0]            pop_data,
  input  logic                    pop_rdy,
  output logic [$clog2(N)-1:0]    rf_wa,
  output logic                    rf_wen,
  output logic [W-1:0]            rf_wdata,
  output logic [$clog2(N)-1:0]    rf_ra,
  output logic                    rf_ren,
  input  logic [W-1:0]            rf_rdata,
  output logic [$clog2(N+2):0]    occ
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned OW = $clog2(N + 2) + 1;

`ifdef RFQ_CTRL_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          infl_q;
  logic [1:0]    stg_cnt_q, stg_cnt_d;
  logic [W-1:0]  head_q, head_d, tail_q, tail_d;
  logic          push_rdy_q;
  logic [OW-1:0] occ_q;

  logic          push_fire, pop_fire, wr_fire, issue, bypass, app;
  logic [1:0]    stg_keep;
  logic [W-1:0]  app_data;

  assign push_fire = push_vld & push_rdy_q;
  assign pop_vld   = (stg_cnt_q != 2'd0);
  assign pop_fire  = pop_vld & pop_rdy;
  assign stg_keep  = stg_cnt_q - {1'b0, pop_fire};

  // Reads are only issued when the word landing next cycle is guaranteed a stage slot.
  assign issue  = (cnt_q != '0) && ((stg_keep + {1'b0, infl_q}) < 2'd2);
  assign bypass = BypassEn && push_fire && (cnt_q == '0) && !infl_q && (stg_keep < 2'd2);
  assign wr_fire = push_fire & ~bypass;

  // A landing read and a bypass write are mutually exclusive (bypass needs no read in flight).
  assign app      = infl_q | bypass;
  assign app_data = infl_q ? rf_rdata : push_data;

  assign cnt_d     = cnt_q + CW'(wr_fire) - CW'(issue);
  assign stg_cnt_d = stg_keep + {1'b0, app};

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop_fire) head_d = tail_q;
    if (app) begin
      if (stg_keep == 2'd0) head_d = app_data;
      else                  tail_d = app_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      infl_q     <= 1'b0;
      stg_cnt_q  <= 2'd0;
      push_rdy_q <= 1'b0;
      occ_q      <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue)   rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q      <= cnt_d;
      infl_q     <= issue;
      stg_cnt_q  <= stg_cnt_d;
      push_rdy_q <= (cnt_d != CW'(N));
      occ_q      <= occ_q + OW'(push_fire) - OW'(pop_fire);
    end
  end

  // Stage data is qualified by stg_cnt_q, so it needs no reset.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign push_rdy = push_rdy_q;
  assign pop_data = head_q;
  assign rf_wen   = wr_fire;
  assign rf_wa    = wr_ptr_q;
  assign rf_wdata = push_data;
  assign rf_ren   = issue;
  assign rf_ra    = rd_ptr_q;
  assign occ      = occ_q;

endmodule

// File: tb/tb_rfq_ctrl.sv
// Directed self-checking bench for rfq_ctrl (N=4, W=8) with a behavioural register file.
module tb_rfq_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         push_vld;
  logic [W-1:0] push_data;
  logic         push_rdy;
  logic         pop_vld;
  logic [W-1:0] pop_data;
  logic         pop_rdy;
  logic [1:0]   rf_wa, rf_ra;
  logic         rf_wen, rf_ren;
  logic [W-1:0] rf_wdata, rf_rdata;
  logic [3:0]   occ;

  rfq_ctrl #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (push_vld),
    .push_data (push_data),
    .push_rdy  (push_rdy),
    .pop_vld   (pop_vld),
    .pop_data  (pop_data),
    .pop_rdy   (pop_rdy),
    .rf_wa     (rf_wa),
    .rf_wen    (rf_wen),
    .rf_wdata  (rf_wdata),
    .rf_ra     (rf_ra),
    .rf_ren    (rf_ren),
    .rf_rdata  (rf_rdata),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [N];
  always_ff @(posedge clk) begin
    if (rf_wen) mem[rf_wa] <= rf_wdata;
    if (rf_ren) rf_rdata <= mem[rf_ra];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] pend[$];
  logic [W-1:0] sb[$];
  int occ_exp, wa_exp, ra_exp, npop, first_pop, last_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes pend[] whenever accepted and scores every pop against the queue model.
  task automatic run(input int cycles);
    logic [31:0] exp_w;
    for (int i = 0; i < cycles; i++) begin
      push_vld  = (pend.size() > 0);
      push_data = push_vld ? pend[0] : 8'h00;
      #1;
      chk("occ", 32'(occ), 32'(occ_exp));
      if (push_vld && push_rdy) begin
`ifndef RFQ_CTRL_BYPASS_EN
        chk("rf_wen", 32'(rf_wen), 32'd1);
        chk("rf_wa", 32'(rf_wa), 32'(wa_exp % N));
        wa_exp++;
`endif
        sb.push_back(pend.pop_front());
        occ_exp++;
      end
      if (rf_ren) begin
        chk("rf_ra", 32'(rf_ra), 32'(ra_exp % N));
        ra_exp++;
      end
      if (pop_vld && pop_rdy) begin
        exp_w = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hxxxx_xxxx;
        chk("pop_order", 32'(pop_data), exp_w);
        if (npop == 0) first_pop = cyc;
        last_pop = cyc;
        npop++;
        occ_exp--;
      end
      tick();
    end
    push_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b0; push_vld = 1'b1; push_data = 8'h00; pop_rdy = 1'b0;
    occ_exp = 0; wa_exp = 0; ra_exp = 0; npop = 0; first_pop = 0; last_pop = 0;

    // Reset state, with a push already offered
    tick();
    chk("rst_push_rdy", 32'(push_rdy), 32'd0);
    chk("rst_pop_vld", 32'(pop_vld), 32'd0);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_rf_ren", 32'(rf_ren), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    push_vld = 1'b0;
    rst = 1'b1;
    tick();
    chk("rel_push_rdy", 32'(push_rdy), 32'd1);

`ifndef RFQ_CTRL_BYPASS_EN
    // Single word latency: write cycle 0, read cycle 1, pop cycle 3
    pop_rdy = 1'b1; push_vld = 1'b1; push_data = 8'hA5;
    #1;
    chk("lat_c0_wen", 32'(rf_wen), 32'd1);
    chk("lat_c0_wa", 32'(rf_wa), 32'd0);
    chk("lat_c0_wdata", 32'(rf_wdata), 32'hA5);
    chk("lat_c0_ren", 32'(rf_ren), 32'd0);
    tick(); push_vld = 1'b0; #1;
    chk("lat_c1_ren", 32'(rf_ren), 32'd1);
    chk("lat_c1_ra", 32'(rf_ra), 32'd0);
    chk("lat_c1_wen", 32'(rf_wen), 32'd0);
    chk("lat_c1_occ", 32'(occ), 32'd1);
    chk("lat_c1_pop_vld", 32'(pop_vld), 32'd0);
    tick();
    chk("lat_c2_pop_vld", 32'(pop_vld), 32'd0);
    tick();
    chk("lat_c3_pop_vld", 32'(pop_vld), 32'd1);
    chk("lat_c3_pop_data", 32'(pop_data), 32'hA5);
    tick();
    chk("lat_c4_pop_vld", 32'(pop_vld), 32'd0);
    chk("lat_c4_occ", 32'(occ), 32'd0);
    wa_exp = 1; ra_exp = 1;
`else
    // Bypass: empty path delivers the word the next cycle without touching storage
    pop_rdy = 1'b1; push_vld = 1'b1; push_data = 8'h3C;
    #1;
    chk("byp_c0_wen", 32'(rf_wen), 32'd0);
    chk("byp_c0_rdy", 32'(push_rdy), 32'd1);
    tick(); push_vld = 1'b0; #1;
    chk("byp_c1_pop_vld", 32'(pop_vld), 32'd1);
    chk("byp_c1_pop_data", 32'(pop_data), 32'h3C);
    tick();
    chk("byp_c2_pop_vld", 32'(pop_vld), 32'd0);
`endif

    // Fill with the consumer stalled: six words fit, the seventh waits
    pop_rdy = 1'b0;
    for (int k = 0; k < 7; k++) pend.push_back(W'(k));
    run(8);
    chk("fill_accepted", 32'(sb.size()), 32'd6);
    push_vld = 1'b1; push_data = 8'h06; #1;
    chk("fill_push_rdy", 32'(push_rdy), 32'd0);
    chk("fill_occ", 32'(occ), 32'd6);
    chk("fill_pop_vld", 32'(pop_vld), 32'd1);
    chk("fill_pop_data", 32'(pop_data), 32'h00);
    chk("fill_no_read", 32'(rf_ren), 32'd0);
    tick();
    chk("hold_pop_data", 32'(pop_data), 32'h00);

    // Full storage, consumer resumes: push_rdy low this cycle, read issues now
    pop_rdy = 1'b1; #1;
    chk("full_push_rdy", 32'(push_rdy), 32'd0);
    chk("full_rf_ren", 32'(rf_ren), 32'd1);
    chk("full_rf_ra", 32'(rf_ra), 32'(ra_exp % N));
    ra_exp++;
    chk("full_pop", 32'(pop_data), 32'(sb.pop_front()));
    occ_exp = 5;
    tick();
    chk("full_push_rdy_rise", 32'(push_rdy), 32'd1);
    npop = 0;
    run(12);
    chk("drain_cnt", 32'(npop), 32'd6);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_occ", 32'(occ), 32'd0);

    // Streaming: 16 words, one pop per cycle, pointers wrap four times
    for (int k = 0; k < 16; k++) pend.push_back(8'h10 + W'(k));
    npop = 0;
    run(24);
    chk("stream_cnt", 32'(npop), 32'd16);
    chk("stream_span", 32'(last_pop - first_pop), 32'd15);
    chk("stream_pend_empty", 32'(pend.size()), 32'd0);

    // Reset mid-operation with three words held
    pop_rdy = 1'b0;
    pend.push_back(8'h40); pend.push_back(8'h41); pend.push_back(8'h42);
    run(3);
    #1;
    chk("pre_rst_occ", 32'(occ), 32'd3);
    chk("pre_rst_pop_vld", 32'(pop_vld), 32'd1);
    rst = 1'b0; #1;
    chk("mid_rst_pop_vld", 32'(pop_vld), 32'd0);
    chk("mid_rst_occ", 32'(occ), 32'd0);
    chk("mid_rst_push_rdy", 32'(push_rdy), 32'd0);
    chk("mid_rst_ren", 32'(rf_ren), 32'd0);
    sb.delete(); pend.delete();
    occ_exp = 0; wa_exp = 0; ra_exp = 0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("post_rst_push_rdy", 32'(push_rdy), 32'd1);
    chk("post_rst_pop_vld", 32'(pop_vld), 32'd0);
    pop_rdy = 1'b1;
    pend.push_back(8'h77);
    npop = 0;
    run(8);
    chk("post_rst_pops", 32'(npop), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rfq_ctrl.md
RFQ_CTRL -- requirements
Module: rfq_ctrl

Interface
REQ-001 SHALL have parameter W, default 32, data width in bits.
REQ-002 SHALL have parameter N, default 8, register-file depth; a power of two, 2 or greater.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port push_vld  input  1  producer word valid.
REQ-006 SHALL have port push_data  input  W  producer word.
REQ-007 SHALL have port push_rdy  output  1  controller accepts word; transfer when push_vld and push_rdy.
REQ-008 SHALL have port pop_vld  output  1  head word valid.
REQ-009 SHALL have port pop_data  output  W  head word.
REQ-010 SHALL have port pop_rdy  input  1  consumer accepts; transfer when pop_vld and pop_rdy.
REQ-011 SHALL have port rf_wa  output  $clog2(N)  storage write address.
REQ-012 SHALL have port rf_wen  output  1  storage write enable.
REQ-013 SHALL have port rf_wdata  output  W  storage write data.
REQ-014 SHALL have port rf_ra  output  $clog2(N)  storage read address.
REQ-015 SHALL have port rf_ren  output  1  storage read enable.
REQ-016 SHALL have port rf_rdata  input  W  storage read data, registered, valid the cycle after rf_ren.
REQ-017 SHALL have port occ  output  $clog2(N+2)+1  words held (storage + in-flight + output stage).

Function
REQ-018 SHALL act as the initiator of a 1W/1R registered-output register file, presenting a FIFO with valid/ready on both sides.
REQ-019 SHALL drive rf_wen=1, rf_wa=wr_ptr, rf_wdata=push_data in the cycle a push transfers; wr_ptr increments modulo N.
REQ-020 SHALL deassert push_rdy when the storage count equals N; push_rdy SHALL NOT depend combinationally on pop_rdy.
REQ-021 SHALL issue rf_ren=1, rf_ra=rd_ptr only when storage count >0 and (output-stage entries + in-flight reads) <2; rd_ptr increments modulo N, and the storage count decrements in the issue cycle.
REQ-022 SHALL only read entries written in an earlier cycle; a read may target the slot being written in the same cycle (pre-edge data is returned).
REQ-023 SHALL capture rf_rdata into a 2-entry in-order output stage the cycle after issue; pop_vld/pop_data SHALL reflect the stage head from a register.
REQ-024 SHALL deliver a word accepted in cycle t as pop_vld in cycle t+3 when the path is idle, with one pop per cycle sustained.
REQ-025 SHALL hold pop_data stable while pop_vld=1 and pop_rdy=0.
REQ-026 SHALL preserve strict FIFO order under any push/pop interleaving and pointer wrap.
REQ-027 SHALL update occ by +push -pop each cycle; simultaneous push and pop leaves occ unchanged; maximum N+2.

Reset
REQ-028 SHALL, while rst=0, immediately force push_rdy=0, pop_vld=0, rf_wen=0, rf_ren=0, occ=0, pointers=0, and drop in-flight reads.
REQ-029 SHALL assert push_rdy the first cycle after rst release; pop_data and storage contents are unreset and don't-care.
REQ-030 SHALL discard all held words on reset mid-operation; no pre-reset data is ever popped afterwards.

Configuration
REQ-031 SHALL, with RFQ_CTRL_BYPASS_EN defined, write a push directly into the output stage (rf_wen=0) when storage count=0, no read is in flight, and the stage has room, giving pop_vld in cycle t+1.
REQ-032 SHALL, without RFQ_CTRL_BYPASS_EN, route every word through storage with REQ-024 latency.

Verification
REQ-033 SHALL cover N=4, W=8, single push 0xA5 in cycle 0 -> rf_wen/wa=0 cycle 0, rf_ren/ra=0 cycle 1, pop_vld with 0xA5 cycle 3.
REQ-034 SHALL cover pop_rdy=0, push 0x00..0x06 -> six accepted, push_rdy low with 0x06 pending, occ=6; then pop_rdy=1 -> 0x00..0x06 in order.
REQ-035 SHALL cover 16 back-to-back pushes 0x10..0x1F with pop_rdy=1 -> 16 consecutive pops in order, pointers wrap four times.
REQ-036 SHALL cover rst asserted with occ=3 -> pop_vld=0, occ=0 at once; after release, push 0x77 -> first pop is 0x77.
REQ-037 SHALL cover RFQ_CTRL_BYPASS_EN defined, push 0x3C into empty -> rf_wen=0, pop_vld with 0x3C in cycle 1.
REQ-038 SHALL cover storage full with push_vld=1 and pop_rdy=1 -> push_rdy stays 0 that cycle, rises after a read issues.
